axis_relu_quant: RTL and testbench

Downstream stage of the perceptron wrapper. It consumes the wide signed perceptron results from that wrapper's AXI-stream master port and applies ReLU, a fixed arithmetic right shift and unsigned saturation. It packs the quantized elements into output words and marks each frame end with `m_axis_last`, ready for DMA or the next layer.

---
 rtl/axis_relu_quant.sv | 118 +++++++++++
 tb/tb_axis_relu_quant.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_relu_quant.sv
// ReLU, arithmetic right shift and unsigned saturation on a signed AXI-stream,
// packing quantized lanes into output beats with frame-end marking.
module axis_relu_quant #(
  parameter int FRAME_LEN         = 2,
  parameter int INPUT_DATA_WIDTH  = 32,
  parameter int Q_WIDTH           = 8,
  parameter int SHIFT             = 4,
  parameter int PACK              = 4,
  localparam int OUTPUT_DATA_WIDTH = Q_WIDTH * PACK
) (
  input  logic                         axi_clk,
  input  logic                         axi_reset_n,
  input  logic                         s_axis_valid,
  input  logic [INPUT_DATA_WIDTH-1:0]  s_axis_data,
  output logic                         s_axis_ready,
  output logic                         m_axis_valid,
  output logic [OUTPUT_DATA_WIDTH-1:0] m_axis_data,
  output logic                         m_axis_last,
  input  logic                         m_axis_ready,
  output logic [15:0]                  sat_count
);

  localparam int W  = INPUT_DATA_WIDTH;
  localparam int OW = OUTPUT_DATA_WIDTH;
  localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [LW-1:0] lane_q, lane_d;
  logic [FW-1:0] elem_q, elem_d;
  logic [OW-1:0] pack_q, pack_d;
  logic [OW-1:0] data_q, data_d;
  logic          last_q, last_d;
  logic          valid_q, valid_d;
  logic [15:0]   sat_q, sat_d;

  logic [W-1:0]       relu;
  logic [W-1:0]       shr;
  logic               sat;
  logic [Q_WIDTH-1:0] q;
  logic               lane_last;
  logic               frame_last;
  logic               completing;
  logic               accept;
  logic [OW-1:0]      merged;

  // r is non-negative, so a logical shift equals the arithmetic one
  always_comb begin
    relu = s_axis_data[W-1] ? '0 : s_axis_data;
    shr  = relu >> SHIFT;
    sat  = (shr >> Q_WIDTH) != '0;
    q    = sat ? '1 : Q_WIDTH'(shr);
  end

  assign lane_last  = (lane_q == LW'(PACK - 1));
  assign frame_last = (elem_q == FW'(FRAME_LEN - 1));
  assign completing = lane_last | frame_last;

  assign s_axis_ready = !completing || !valid_q || m_axis_ready;
  assign accept       = s_axis_valid && s_axis_ready;

  // lanes above lane_q are still zero, which pads a short final beat
  assign merged = pack_q | (OW'(q) << (lane_q * Q_WIDTH));

  always_comb begin
    lane_d  = lane_q;
    elem_d  = elem_q;
    pack_d  = pack_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    sat_d   = sat_q;
    if (valid_q && m_axis_ready) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      elem_d = frame_last ? '0 : elem_q + 1'b1;
      if (sat && sat_q != 16'hFFFF) begin
        sat_d = sat_q + 16'd1;
      end
      if (completing) begin
        data_d  = merged;
        last_d  = frame_last;
        valid_d = 1'b1;
        pack_d  = '0;
        lane_d  = '0;
      end else begin
        pack_d = merged;
        lane_d = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      lane_q  <= '0;
      elem_q  <= '0;
      pack_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      sat_q   <= '0;
    end else begin
      lane_q  <= lane_d;
      elem_q  <= elem_d;
      pack_q  <= pack_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign m_axis_valid = valid_q;
  assign m_axis_data  = data_q;
  assign m_axis_last  = last_q;
  assign sat_count    = sat_q;

endmodule

// File: tb/tb_axis_relu_quant.sv
// Directed bench for axis_relu_quant: a FRAME_LEN=2 instance for most
// scenarios and a FRAME_LEN=6 instance for multi-beat frames.
module tb_axis_relu_quant;

  logic        clk;
  logic        rst_n;

  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_last;
  logic        m_ready;
  logic [15:0] sat_cnt;

  logic        s_valid6;
  logic [31:0] s_data6;
  logic        s_ready6;
  logic        m_valid6;
  logic [31:0] m_data6;
  logic        m_last6;
  logic        m_ready6;
  logic [15:0] sat_cnt6;

  int passed;
  int total;

  axis_relu_quant #(.FRAME_LEN(2)) u_dut (
    .axi_clk      (clk),
    .axi_reset_n  (rst_n),
    .s_axis_valid (s_valid),
    .s_axis_data  (s_data),
    .s_axis_ready (s_ready),
    .m_axis_valid (m_valid),
    .m_axis_data  (m_data),
    .m_axis_last  (m_last),
    .m_axis_ready (m_ready),
    .sat_count    (sat_cnt)
  );

  axis_relu_quant #(.FRAME_LEN(6)) u_dut6 (
    .axi_clk      (clk),
    .axi_reset_n  (rst_n),
    .s_axis_valid (s_valid6),
    .s_axis_data  (s_data6),
    .s_axis_ready (s_ready6),
    .m_axis_valid (m_valid6),
    .m_axis_data  (m_data6),
    .m_axis_last  (m_last6),
    .m_axis_ready (m_ready6),
    .sat_count    (sat_cnt6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input bit six, input logic [31:0] x);
    logic rdy;
    rdy = 1'b0;
    if (six) begin
      s_valid6 = 1'b1;
      s_data6  = x;
    end else begin
      s_valid = 1'b1;
      s_data  = x;
    end
    for (int n = 0; n < 50; n++) begin
      #1;
      rdy = six ? s_ready6 : s_ready;
      if (rdy) break;
      @(negedge clk);
    end
    if (!rdy) chk("push_timeout", 32'(rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_valid  = 1'b0;
    s_valid6 = 1'b0;
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b1;
    s_valid6 = 1'b0;
    s_data6  = '0;
    m_ready6 = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", m_data, 32'h0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_sat", 32'(sat_cnt), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // basic frame
    push(0, 32'h0000_0100);
    chk("basic_no_early", 32'(m_valid), 32'd0);
    push(0, 32'hFFFF_FF00);
    chk("basic_valid", 32'(m_valid), 32'd1);
    chk("basic_data", m_data, 32'h0000_0010);
    chk("basic_last", 32'(m_last), 32'd1);
    chk("basic_sat", 32'(sat_cnt), 32'd0);
    @(negedge clk);
    chk("basic_drained", 32'(m_valid), 32'd0);

    // saturation
    push(0, 32'h0001_0000);
    push(0, 32'h0000_07F0);
    chk("sat_data", m_data, 32'h0000_7FFF);
    chk("sat_last", 32'(m_last), 32'd1);
    chk("sat_count1", 32'(sat_cnt), 32'd1);
    @(negedge clk);

    // multi-beat frame on the FRAME_LEN=6 instance
    push(1, 32'h10);
    push(1, 32'h20);
    push(1, 32'h30);
    push(1, 32'h40);
    chk("mb_beat0_valid", 32'(m_valid6), 32'd1);
    chk("mb_beat0_data", m_data6, 32'h0403_0201);
    chk("mb_beat0_last", 32'(m_last6), 32'd0);
    push(1, 32'h50);
    chk("mb_gap", 32'(m_valid6), 32'd0);
    push(1, 32'h60);
    chk("mb_beat1_valid", 32'(m_valid6), 32'd1);
    chk("mb_beat1_data", m_data6, 32'h0000_0605);
    chk("mb_beat1_last", 32'(m_last6), 32'd1);
    @(negedge clk);

    // backpressure across three frames
    m_ready = 1'b0;
    push(0, 32'h100);
    push(0, 32'h200);
    chk("bp_beat1_data", m_data, 32'h0000_2010);
    push(0, 32'h300);
    chk("bp_hold_data", m_data, 32'h0000_2010);
    s_valid = 1'b1;
    s_data  = 32'h400;
    #1;
    chk("bp_s_ready_low", 32'(s_ready), 32'd0);
    @(negedge clk);
    chk("bp_hold_valid", 32'(m_valid), 32'd1);
    chk("bp_hold_data2", m_data, 32'h0000_2010);
    chk("bp_hold_last", 32'(m_last), 32'd1);
    m_ready = 1'b1;
    #1;
    chk("bp_s_ready_high", 32'(s_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    chk("bp_reload_valid", 32'(m_valid), 32'd1);
    chk("bp_beat2_data", m_data, 32'h0000_4030);
    push(0, 32'h500);
    chk("bp_no_dup", 32'(m_valid), 32'd0);
    push(0, 32'h600);
    chk("bp_beat3_data", m_data, 32'h0000_6050);
    chk("bp_beat3_last", 32'(m_last), 32'd1);
    @(negedge clk);
    chk("bp_empty", 32'(m_valid), 32'd0);

    // reset mid-frame
    push(0, 32'h0000_0FF0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_sat", 32'(sat_cnt), 32'd0);
    chk("mid_rst_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push(0, 32'h100);
    chk("mid_no_early", 32'(m_valid), 32'd0);
    push(0, 32'h200);
    chk("mid_data", m_data, 32'h0000_2010);
    chk("mid_last", 32'(m_last), 32'd1);
    @(negedge clk);

    // saturating counter
    s_valid = 1'b1;
    s_data  = 32'h7FFF_FFFF;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("satcnt_fffe", 32'(sat_cnt), 32'h0000_FFFE);
    repeat (6) @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    chk("satcnt_stick", 32'(sat_cnt), 32'h0000_FFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
